// File: rtl/seq_sub16_pkg.sv
// seq_sub16_pkg: shared constants, FSM state type and nibble helper for the
// sequential 16-bit subtractor (seq_sub16).
//   WIDTH    - operand/result width (16)
//   SLICE_W  - bits processed per cycle (4)
//   CNT_W    - nibble counter width
//   state_t  - IDLE / RUN / DONE
package seq_sub16_pkg;

  localparam int WIDTH   = 16;
  localparam int SLICE_W = 4;
  localparam int NUM_NIB = WIDTH / SLICE_W;
  localparam int CNT_W   = 2;

  localparam logic [CNT_W-1:0] LAST_NIB = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Select one nibble of a 16-bit word by counter value.
  function automatic logic [SLICE_W-1:0] nibble_sel(input logic [WIDTH-1:0] v,
                                                    input logic [CNT_W-1:0] idx);
    case (idx)
      2'd0:    nibble_sel = v[3:0];
      2'd1:    nibble_sel = v[7:4];
      2'd2:    nibble_sel = v[11:8];
      2'd3:    nibble_sel = v[15:12];
      default: nibble_sel = v[3:0];
    endcase
  endfunction

endpackage

// File: rtl/seq_sub16_if.sv
// seq_sub16_if: request/result bundle for seq_sub16.
//   start, a, b                         - request side (driven by master)
//   busy, done, diff, borrow, zero,
//   overflow                            - result side (driven by slave)
interface seq_sub16_if;
  import seq_sub16_pkg::*;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, zero, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, zero, overflow
  );
endinterface

// File: rtl/seq_sub16_cla4_slice.sv
// cla4_slice: 4-bit carry-lookahead adder slice.
//   x, y  - 4-bit addends
//   cin   - carry in
//   s     - 4-bit sum
//   cout  - carry out of bit 3
//   gp/gg - group propagate / group generate
//   c3    - carry into bit 3 (overflow tap)
module cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       gp,
  output logic       gg,
  output logic       c3
);
  logic [3:0] p;
  logic [3:0] g;
  logic       c1;
  logic       c2;

  assign p  = x ^ y;
  assign g  = x & y;
  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign gp = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign cout = gg | (gp & cin);
  assign s  = p ^ {c3, c2, c1, cin};
endmodule

// File: rtl/seq_sub16.sv
// seq_sub16: sequential 16-bit subtractor, diff = a + ~b + 1, one nibble per
// cycle through a single 4-bit CLA slice with a registered inter-nibble carry.
//   clk  - clock (rising edge)
//   rst  - synchronous active-high reset
//   bus  - seq_sub16_if.slave (start/a/b in; busy/done/diff/flags out)
// Build option: define SEQ_SUB16_OVF_EN to enable the signed overflow flag;
// otherwise overflow is tied to 0.
module seq_sub16
  import seq_sub16_pkg::*;
(
  input logic         clk,
  input logic         rst,
  seq_sub16_if.slave  bus
);
  state_t state;
  state_t next_state;

  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_lat;
  logic [WIDTH-1:0]   b_lat;
  logic [11:0]        acc;      // lower nibbles of the result, shifted in LSB first
  logic [WIDTH-1:0]   diff;
  logic               carry;
  logic               busy;
  logic               done;
  logic               borrow;
  logic               zero;
  logic               accept;
  logic               last_nib;

  logic [SLICE_W-1:0] x;
  logic [SLICE_W-1:0] y;
  logic [SLICE_W-1:0] s;
  logic               cout;
  logic               gp;
  logic               gg;

  assign x = nibble_sel(a_lat, cnt);
  assign y = ~nibble_sel(b_lat, cnt);

`ifdef SEQ_SUB16_OVF_EN
  logic c3;
  logic overflow;

  cla4_slice u_slice (
    .x    (x),
    .y    (y),
    .cin  (carry),
    .s    (s),
    .cout (cout),
    .gp   (gp),
    .gg   (gg),
    .c3   (c3)
  );
`else
  logic unused_c3;

  cla4_slice u_slice (
    .x    (x),
    .y    (y),
    .cin  (carry),
    .s    (s),
    .cout (cout),
    .gp   (gp),
    .gg   (gg),
    .c3   (unused_c3)
  );
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus accept / last-nibble strobes
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last_nib   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          next_state = RUN;
          accept     = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if (cnt == LAST_NIB) begin
          next_state = DONE;
          last_nib   = 1'b1;
        end else begin
          next_state = RUN;
        end
      end
      DONE: begin
        // a start in the done cycle chains straight into the next operation
        if (bus.start) begin
          next_state = RUN;
          accept     = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Operand latch, nibble datapath and registered result/flags
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= {CNT_W{1'b0}};
      a_lat  <= {WIDTH{1'b0}};
      b_lat  <= {WIDTH{1'b0}};
      acc    <= 12'd0;
      carry  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= {WIDTH{1'b0}};
      borrow <= 1'b0;
      zero   <= 1'b1;
`ifdef SEQ_SUB16_OVF_EN
      overflow <= 1'b0;
`endif
    end else begin
      done <= last_nib;
      if (accept) begin
        a_lat <= bus.a;
        b_lat <= bus.b;
        cnt   <= {CNT_W{1'b0}};
        carry <= 1'b1;     // +1 of the two's complement of b
        busy  <= 1'b1;
      end else if (state == RUN) begin
        acc   <= {s, acc[11:4]};
        carry <= gg | (gp & carry);
        cnt   <= cnt + 2'd1;
        if (last_nib) begin
          // result is committed only here so outputs stay stable while busy
          busy   <= 1'b0;
          diff   <= {s, acc};
          borrow <= ~cout;
          zero   <= ({s, acc} == 16'd0);
`ifdef SEQ_SUB16_OVF_EN
          overflow <= c3 ^ cout;
`endif
        end
      end
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.diff   = diff;
  assign bus.borrow = borrow;
  assign bus.zero   = zero;
`ifdef SEQ_SUB16_OVF_EN
  assign bus.overflow = overflow;
`else
  assign bus.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_seq_sub16.sv
// tb_seq_sub16: self-checking bench for seq_sub16 (table of directed vectors
// plus hand-written sequences for chaining, held start and mid-op reset).
module tb_seq_sub16;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

`ifdef SEQ_SUB16_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] diff;
    logic        borrow;
    logic        zero;
    logic        ovf;
  } vec_t;

  vec_t vecs [8];

  seq_sub16_if bus ();

  seq_sub16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk16(input string tag, input string what,
                       input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s_%s: got %0d expected %0d", tag, what, act, exp);
    end
  endtask

  task automatic chk1(input string tag, input string what,
                      input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s_%s: got %0b expected %0b", tag, what, act, exp);
    end
  endtask

  // Entered at the negedge right after the accepting edge; returns at the done-cycle negedge.
  task automatic wait_done(input string tag);
    int lat;
    int busy_cnt;
    bit seen;
    lat      = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (!seen && lat < 10) begin
      chk1(tag, "excl", bus.busy & bus.done, 1'b0);
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (bus.busy) busy_cnt++;
        @(negedge clk);
        lat++;
      end
    end
    chk1(tag, "done_seen", seen, 1'b1);
    chk16(tag, "latency", lat[15:0], 16'd4);
    chk16(tag, "busy_cycles", busy_cnt[15:0], 16'd4);
  endtask

  // Entered at a negedge where the DUT can accept; operands are perturbed after acceptance.
  task automatic run_op(input logic [15:0] ai, input logic [15:0] bi, input string tag);
    bus.a     = ai;
    bus.b     = bi;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~ai;
    bus.b     = ~bi;
    wait_done(tag);
  endtask

  initial begin
    int dcount;
    tests = 0;
    fails = 0;

    vecs[0] = '{16'd1036,  16'd414,   16'd622,   1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'd414,   16'd1036,  16'd64914, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'd32768, 16'd1,     16'd32767, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{16'd65535, 16'd65535, 16'd0,     1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'd5045,  16'd45042, 16'd25539, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{16'd0,     16'd1,     16'd65535, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{16'd32767, 16'd65535, 16'd32768, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{16'd32767, 16'd32768, 16'd65535, 1'b1, 1'b0, 1'b1};

    // reset state
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = 16'd0;
    bus.b     = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst", "busy", bus.busy, 1'b0);
    chk1("rst", "done", bus.done, 1'b0);
    chk16("rst", "diff", bus.diff, 16'd0);
    chk1("rst", "zero", bus.zero, 1'b1);
    chk1("rst", "borrow", bus.borrow, 1'b0);
    chk1("rst", "ovf", bus.overflow, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // table-driven vectors
    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run_op(vecs[i].a, vecs[i].b, tag);
      chk16(tag, "diff", bus.diff, vecs[i].diff);
      chk1(tag, "borrow", bus.borrow, vecs[i].borrow);
      chk1(tag, "zero", bus.zero, vecs[i].zero);
      chk1(tag, "ovf", bus.overflow, vecs[i].ovf & OVF_EN);
      @(negedge clk);
      chk1(tag, "done_pulse", bus.done, 1'b0);
      chk16(tag, "diff_hold", bus.diff, vecs[i].diff);
    end

    // restart in the done cycle; previous result must be held while busy
    run_op(16'd65535, 16'd65535, "b2b1");
    chk16("b2b1", "diff", bus.diff, 16'd0);
    chk1("b2b1", "zero", bus.zero, 1'b1);
    chk1("b2b1", "borrow", bus.borrow, 1'b0);
    bus.a     = 16'd5045;
    bus.b     = 16'd45042;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk1("b2b2", "busy_next", bus.busy, 1'b1);
    chk16("b2b2", "diff_held", bus.diff, 16'd0);
    chk1("b2b2", "zero_held", bus.zero, 1'b1);
    wait_done("b2b2");
    chk16("b2b2", "diff", bus.diff, 16'd25539);
    chk1("b2b2", "borrow", bus.borrow, 1'b1);
    chk1("b2b2", "zero", bus.zero, 1'b0);
    @(negedge clk);

    // start held high through busy with changing operands
    bus.a     = 16'd1036;
    bus.b     = 16'd414;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.a  = 16'd9;
    bus.b  = 16'd3;
    dcount = 0;
    for (int s = 0; s <= 12; s++) begin
      chk1("held", "excl", bus.busy & bus.done, 1'b0);
      if (bus.done) begin
        dcount++;
        if (dcount == 1) begin
          chk16("held1", "diff", bus.diff, 16'd622);
          chk16("held1", "cycle", s[15:0], 16'd4);
        end else begin
          chk16("held2", "diff", bus.diff, 16'd6);
          chk16("held2", "cycle", s[15:0], 16'd9);
        end
      end
      if (s == 5) begin
        bus.a = 16'd7;
        bus.b = 16'd2;
      end
      if (s == 9) bus.start = 1'b0;
      @(negedge clk);
    end
    chk16("held", "done_count", dcount[15:0], 16'd2);

    // reset while nibble 2 is in progress, with start asserted alongside
    bus.a     = 16'd1036;
    bus.b     = 16'd414;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    chk1("midrst", "busy", bus.busy, 1'b0);
    chk1("midrst", "done", bus.done, 1'b0);
    chk16("midrst", "diff", bus.diff, 16'd0);
    chk1("midrst", "zero", bus.zero, 1'b1);
    @(negedge clk);
    chk1("midrst", "busy_prio", bus.busy, 1'b0);
    rst       = 1'b0;
    bus.start = 1'b0;
    dcount    = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done) dcount++;
    end
    chk16("midrst", "no_done", dcount[15:0], 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seq_sub16.md
SEQ_SUB16 -- requirements
Module: seq_sub16

Interface
REQ-001 Parameters: none; width fixed at 16 bits, slice width fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; sampled only when busy=0.
REQ-005 a  input  16  minuend, unsigned or two's complement.
REQ-006 b  input  16  subtrahend, unsigned or two's complement.
REQ-007 busy  output  1  high while a subtraction is in progress.
REQ-008 done  output  1  one-cycle pulse when the result becomes valid.
REQ-009 diff  output  16  a - b mod 2^16; held until the next accepted start.
REQ-010 borrow  output  1  1 iff unsigned a < b.
REQ-011 zero  output  1  1 iff diff == 0.
REQ-012 overflow  output  1  signed overflow of a - b; see Configuration.

Function
REQ-013 Compute diff as a + ~b + 1, 4 bits per cycle through a 4-bit carry-lookahead slice; nibble order 0 to 3.
REQ-014 Registered carry between nibbles; initial carry-in = 1.
REQ-015 FSM states:
  - IDLE -> RUN on start.
  - RUN stays RUN while nibble counter < 3; RUN -> DONE after nibble 3.
  - DONE -> IDLE, or DONE -> RUN if start is high.
REQ-016 On an accepted start, latch a and b; busy goes high from the next cycle; the nibble counter clears to 0.
REQ-017 Latency: start accepted at edge T; done = 1 in the cycle after edge T+4; busy = 1 for exactly 4 cycles.
REQ-018 start while busy = 1 is ignored; latched operands are unchanged.
REQ-019 start in the done cycle is accepted; done and busy never assert together.
REQ-020 a/b changes after the start edge do not affect the result.
REQ-021 borrow = NOT final carry-out.
REQ-022 zero, borrow and overflow update together with diff.
REQ-023 diff, borrow, zero and overflow are stable from the done cycle until the next done.

Reset
REQ-024 rst has priority over start.
REQ-025 On rst, go to IDLE and clear to 0: busy, done, diff, borrow, overflow and the nibble counter.
REQ-026 zero resets to 1, consistent with diff = 0.
REQ-027 rst mid-operation aborts the operation; no done follows.

Configuration
REQ-028 Macro SEQ_SUB16_OVF_EN controls the overflow flag.
REQ-029 Defined: overflow = carry into bit 15 XOR carry out of bit 15, registered with diff.
REQ-030 Undefined: overflow is tied 0 and the bit-15 carry tap logic is omitted.

Structure
REQ-031 Shared package holds: width and slice-width constants, the FSM state typedef (IDLE/RUN/DONE), and the nibble-counter width.
REQ-032 One sub-module, cla4_slice:
  - inputs: 4-bit x, 4-bit y, 1-bit cin.
  - outputs: 4-bit s, cout, group propagate, group generate, and c3 (carry into bit 3, for overflow).
REQ-033 Instantiate cla4_slice exactly once; operand nibbles are muxed by the counter.

Verification
REQ-034 a=1036, b=414, start -> done 4 cycles later; diff=622, borrow=0, zero=0, overflow=0.
REQ-035 a=414, b=1036 -> diff=64914, borrow=1, zero=0, overflow=0.
REQ-036 a=32768, b=1 -> diff=32767, borrow=0, overflow=1 with the macro defined, 0 without it.
REQ-037 a=65535, b=65535 -> diff=0, zero=1, borrow=0; then start again in the done cycle with a=5045, b=45042 -> diff=25539, borrow=1.
REQ-038 start held high during busy with new operands -> exactly one done per 5-cycle cycle, using only the operands latched at acceptance.
REQ-039 rst asserted at nibble 2 -> next cycle busy=0, diff=0, zero=1, and no done pulse.
